i2c_target_regs: RTL and testbench
==================================

I2C_TARGET_REGS -- requirements
Module: i2c_target_regs

Interface
REQ-001 Parameter FILTER_LEN, default 3, is the number of consecutive equal samples required to accept a new filtered SCL/SDA level.
REQ-002 Signal clk  input  1  is the system clock; all logic is on its rising edge.
REQ-003 Signal rst  input  1  is the reset: synchronous, active-high.
REQ-004 Signal scl_i  input  1  is the raw, asynchronous I2C clock pin.
REQ-005 Signal sda_i  input  1  is the raw, asynchronous I2C data pin.
REQ-006 Signal sda_oe  output  1  means pull SDA low when 1 and release when 0; the block never drives SCL.
REQ-007 Signal own_addr  input  7  is the 7-bit target address; it is sampled only at the address-byte compare.
REQ-008 Signals host_idx (input, 3) and host_wdata (input, 8) are the host register index and write data.
REQ-009 Signal host_we  input  1  writes host_wdata to reg[host_idx] when 1.
REQ-010 Signal host_rdata  output  8  is reg[host_idx], combinational.
REQ-011 Signal wr_pulse  output  1  is a one-cycle strobe asserted when an I2C write updates a register.
REQ-012 Signal wr_idx  output  3  is the register index of the last I2C write.
REQ-013 Signal busy  output  1  is high from an address match until the next STOP or START.

Function
REQ-014 scl_i and sda_i SHALL each pass through a 2-flop synchronizer, then a FILTER_LEN-sample glitch filter, before any use.
REQ-015 START and repeated START SHALL be detected as filtered SDA 1->0 while filtered SCL=1; STOP SHALL be detected as SDA 0->1 while SCL=1.
REQ-016 START and STOP SHALL take effect from any state: on START go to ADDR with bit count 0; on STOP go to IDLE; sda_oe SHALL be 0 on the next cycle in both cases.
REQ-017 The state set SHALL be exactly IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
REQ-018 Data bits SHALL be sampled on the filtered SCL rising edge, MSB first; sda_oe SHALL change only on the filtered SCL falling edge, except as REQ-016 requires.
REQ-019 In ADDR, after 8 bits: if bits[7:1]==own_addr, go to ADDR_ACK and set sda_oe=1 at the next SCL fall; otherwise go to IGNORE with sda_oe=0.
REQ-020 IGNORE SHALL keep sda_oe=0 until START or STOP.
REQ-021 ACK phase: sda_oe=1 from the SCL fall after bit 8 to the SCL fall after bit 9, where it is released.
REQ-022 R/W=0 path: ADDR_ACK->PTR; the PTR byte sets ptr=byte[2:0] (bits 7:3 ignored) and is ACKed; then PTR_ACK->WDATA.
REQ-023 Each WDATA byte SHALL write reg[ptr], pulse wr_pulse for one cycle with wr_idx=ptr at the 8th SCL rise, be ACKed, and then set ptr=ptr+1 mod 8.
REQ-024 R/W=1 path: ADDR_ACK->RDATA; reg[ptr] SHALL be copied into the TX shift register at the ACK-release SCL fall; bit 7 SHALL be driven as sda_oe=~bit on that same fall; then ptr=ptr+1 mod 8.
REQ-025 In RDATA, sda_oe SHALL be released after the 8th bit; in RDATA_ACK the master's bit is sampled: 0 (ACK) -> next RDATA byte, 1 (NACK) -> IGNORE.
REQ-026 A read SHALL transmit the value latched at the byte start; host writes mid-byte SHALL NOT corrupt it.
REQ-027 When host_we and an I2C write target the same register in the same cycle, the I2C write SHALL win; in all other cases host_we writes in that cycle.
REQ-028 A repeated START after PTR_ACK SHALL keep ptr, enabling a write-pointer-then-read sequence.
REQ-029 No clock stretching; no 10-bit addressing; general-call address 0 SHALL NOT be ACKed unless own_addr==0.

Reset
REQ-030 On rst: state=IDLE, sda_oe=0, busy=0, wr_pulse=0, wr_idx=0, ptr=0, all 8 registers=8'h00, synchronizer/filter flops=1.
REQ-031 rst asserted mid-transaction SHALL release SDA on the next cycle; after rst deasserts, the block SHALL ignore the bus until a fresh START.

Verification
REQ-032 Bench SHALL check: own_addr=0x42; START, 0x84, 0x03, 0xA5, STOP -> ACK on all 3 bytes, reg[3]=0xA5, one wr_pulse with wr_idx=3, busy low after STOP.
REQ-033 Bench SHALL check: host writes reg[7]=0x11 and reg[0]=0x22; START 0x84, 0x07, Sr, 0x85, master reads 2 bytes ACK then NACK, STOP -> bytes 0x11 then 0x22 (ptr wrap), sda_oe=0 after NACK.
REQ-034 Bench SHALL check: START, 0x86 (address 0x43) -> no ACK, sda_oe=0 throughout, state IGNORE, subsequent bytes ignored until STOP.
REQ-035 Bench SHALL check: a 1-cycle SCL glitch with FILTER_LEN=3 -> no bit counted, no state change.
REQ-036 Bench SHALL check: host_we to reg[2] while the I2C master writes reg[2] in the same cycle -> reg[2] holds the I2C value.
REQ-037 Bench SHALL check: rst asserted during RDATA while sda_oe=1 -> sda_oe=0 next cycle, all registers 0x00, no ACK to the following bytes before a new START.

Source files
------------

// File: rtl/i2c_target_regs_if.sv
// Bus bundle for the I2C target register block: raw I2C pins plus the host
// register port and I2C write status.
interface i2c_target_regs_if;
  logic       scl_i;
  logic       sda_i;
  logic       sda_oe;
  logic [2:0] host_idx;
  logic [7:0] host_wdata;
  logic       host_we;
  logic [7:0] host_rdata;
  logic       wr_pulse;
  logic [2:0] wr_idx;
  logic       busy;

  modport slave (
    input  scl_i, sda_i, host_idx, host_wdata, host_we,
    output sda_oe, host_rdata, wr_pulse, wr_idx, busy
  );

  modport master (
    output scl_i, sda_i, host_idx, host_wdata, host_we,
    input  sda_oe, host_rdata, wr_pulse, wr_idx, busy
  );
endinterface

// File: rtl/i2c_target_regs.sv
// I2C target exposing eight 8-bit registers: pointer-byte writes, auto-increment
// reads/writes, filtered SCL/SDA inputs and a host-side register port.
module i2c_target_regs #(
  parameter int FILTER_LEN = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            own_addr,
  i2c_target_regs_if.slave      bus
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    ADDR      = 4'd1,
    ADDR_ACK  = 4'd2,
    PTR       = 4'd3,
    PTR_ACK   = 4'd4,
    WDATA     = 4'd5,
    WDATA_ACK = 4'd6,
    RDATA     = 4'd7,
    RDATA_ACK = 4'd8,
    IGNORE    = 4'd9
  } state_t;

  // Index 0 carries SCL, index 1 carries SDA.
  logic [1:0]    sync1_r, sync2_r, filt_r, filt_d_r;
  logic [CW-1:0] cnt_r [2];

  state_t     state_r, state_nx_s;
  logic [3:0] bit_cnt_r, bit_cnt_nx_s;
  logic [6:0] shift_r, shift_nx_s;
  logic [6:0] tx_r, tx_nx_s;
  logic [2:0] ptr_r, ptr_nx_s;
  logic       rw_r, rw_nx_s;
  logic       sda_oe_r, sda_oe_nx_s;
  logic       busy_r, busy_nx_s;
  logic       wr_pulse_r, wr_pulse_nx_s;
  logic [2:0] wr_idx_r, wr_idx_nx_s;
  logic       load_tx_s, i2c_we_s;
  logic [7:0] regs_r [8];

  logic       scl_rise_s, scl_fall_s, start_s, stop_s;
  logic [7:0] rx_byte_s;

  // Two-flop synchronizers followed by a consecutive-sample glitch filter.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r  <= 2'b11;
      sync2_r  <= 2'b11;
      filt_r   <= 2'b11;
      filt_d_r <= 2'b11;
      for (int i = 0; i < 2; i++) cnt_r[i] <= {CW{1'b0}};
    end else begin
      sync1_r  <= {bus.sda_i, bus.scl_i};
      sync2_r  <= sync1_r;
      filt_d_r <= filt_r;
      for (int i = 0; i < 2; i++) begin
        if (sync2_r[i] == filt_r[i]) begin
          cnt_r[i] <= {CW{1'b0}};
        end else if (cnt_r[i] == CW'(FILTER_LEN - 1)) begin
          filt_r[i] <= sync2_r[i];
          cnt_r[i]  <= {CW{1'b0}};
        end else begin
          cnt_r[i] <= cnt_r[i] + CW'(1);
        end
      end
    end
  end

  assign scl_rise_s = filt_r[0] & ~filt_d_r[0];
  assign scl_fall_s = ~filt_r[0] & filt_d_r[0];
  assign start_s    = filt_r[0] & filt_d_r[0] & filt_d_r[1] & ~filt_r[1];
  assign stop_s     = filt_r[0] & filt_d_r[0] & ~filt_d_r[1] & filt_r[1];
  assign rx_byte_s  = {shift_r, filt_r[1]};

  // Protocol next-state and output decode; START/STOP override every state.
  always_comb begin
    state_nx_s    = state_r;
    bit_cnt_nx_s  = bit_cnt_r;
    shift_nx_s    = shift_r;
    tx_nx_s       = tx_r;
    ptr_nx_s      = ptr_r;
    rw_nx_s       = rw_r;
    sda_oe_nx_s   = sda_oe_r;
    busy_nx_s     = busy_r;
    wr_pulse_nx_s = 1'b0;
    wr_idx_nx_s   = wr_idx_r;
    load_tx_s     = 1'b0;
    i2c_we_s      = 1'b0;
    if (start_s) begin
      state_nx_s   = ADDR;
      bit_cnt_nx_s = 4'd0;
      sda_oe_nx_s  = 1'b0;
      busy_nx_s    = 1'b0;
    end else if (stop_s) begin
      state_nx_s  = IDLE;
      sda_oe_nx_s = 1'b0;
      busy_nx_s   = 1'b0;
    end else begin
      case (state_r)
        ADDR, PTR, WDATA: begin
          if (scl_rise_s) begin
            shift_nx_s = rx_byte_s[6:0];
            if (bit_cnt_r == 4'd7) begin
              bit_cnt_nx_s = 4'd0;
              if (state_r == ADDR) begin
                if (rx_byte_s[7:1] == own_addr) begin
                  state_nx_s = ADDR_ACK;
                  rw_nx_s    = rx_byte_s[0];
                  busy_nx_s  = 1'b1;
                end else begin
                  state_nx_s = IGNORE;
                end
              end else if (state_r == PTR) begin
                ptr_nx_s   = rx_byte_s[2:0];
                state_nx_s = PTR_ACK;
              end else begin
                i2c_we_s      = 1'b1;
                wr_pulse_nx_s = 1'b1;
                wr_idx_nx_s   = ptr_r;
                state_nx_s    = WDATA_ACK;
              end
            end else begin
              bit_cnt_nx_s = bit_cnt_r + 4'd1;
            end
          end else begin
            shift_nx_s = shift_r;
          end
        end
        ADDR_ACK, PTR_ACK, WDATA_ACK: begin
          // First SCL fall asserts the ACK, the second releases it.
          if (scl_fall_s) begin
            if (!sda_oe_r) begin
              sda_oe_nx_s = 1'b1;
            end else if (state_r == ADDR_ACK && rw_r) begin
              load_tx_s = 1'b1;
            end else begin
              sda_oe_nx_s  = 1'b0;
              bit_cnt_nx_s = 4'd0;
              if (state_r == ADDR_ACK) begin
                state_nx_s = PTR;
              end else if (state_r == WDATA_ACK) begin
                ptr_nx_s   = ptr_r + 3'd1;
                state_nx_s = WDATA;
              end else begin
                state_nx_s = WDATA;
              end
            end
          end else begin
            sda_oe_nx_s = sda_oe_r;
          end
        end
        RDATA: begin
          if (scl_rise_s) begin
            bit_cnt_nx_s = bit_cnt_r + 4'd1;
          end else if (scl_fall_s) begin
            if (bit_cnt_r == 4'd8) begin
              sda_oe_nx_s = 1'b0;
              state_nx_s  = RDATA_ACK;
            end else begin
              sda_oe_nx_s = ~tx_r[6];
              tx_nx_s     = {tx_r[5:0], 1'b0};
            end
          end else begin
            tx_nx_s = tx_r;
          end
        end
        RDATA_ACK: begin
          if (scl_rise_s) begin
            if (filt_r[1]) begin
              state_nx_s = IGNORE;
            end else begin
              state_nx_s = RDATA_ACK;
            end
          end else if (scl_fall_s) begin
            load_tx_s = 1'b1;
          end else begin
            state_nx_s = RDATA_ACK;
          end
        end
        default: begin
          state_nx_s = state_r;
        end
      endcase
      // Byte start of a read: latch the register so host writes cannot corrupt it.
      if (load_tx_s) begin
        tx_nx_s      = regs_r[ptr_r][6:0];
        sda_oe_nx_s  = ~regs_r[ptr_r][7];
        ptr_nx_s     = ptr_r + 3'd1;
        bit_cnt_nx_s = 4'd0;
        state_nx_s   = RDATA;
      end else begin
        tx_nx_s = tx_nx_s;
      end
    end
  end

  // Protocol state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      bit_cnt_r  <= 4'd0;
      shift_r    <= 7'd0;
      tx_r       <= 7'd0;
      ptr_r      <= 3'd0;
      rw_r       <= 1'b0;
      sda_oe_r   <= 1'b0;
      busy_r     <= 1'b0;
      wr_pulse_r <= 1'b0;
      wr_idx_r   <= 3'd0;
    end else begin
      state_r    <= state_nx_s;
      bit_cnt_r  <= bit_cnt_nx_s;
      shift_r    <= shift_nx_s;
      tx_r       <= tx_nx_s;
      ptr_r      <= ptr_nx_s;
      rw_r       <= rw_nx_s;
      sda_oe_r   <= sda_oe_nx_s;
      busy_r     <= busy_nx_s;
      wr_pulse_r <= wr_pulse_nx_s;
      wr_idx_r   <= wr_idx_nx_s;
    end
  end

  // Register file; the I2C write is issued last so it wins a same-index collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) regs_r[i] <= 8'h00;
    end else begin
      if (bus.host_we) regs_r[bus.host_idx] <= bus.host_wdata;
      if (i2c_we_s) regs_r[ptr_r] <= rx_byte_s;
    end
  end

  assign bus.host_rdata = regs_r[bus.host_idx];
  assign bus.sda_oe     = sda_oe_r;
  assign bus.busy       = busy_r;
  assign bus.wr_pulse   = wr_pulse_r;
  assign bus.wr_idx     = wr_idx_r;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench for i2c_target_regs: a bit-banged I2C master on a wired-AND
// SDA line, host port accesses, glitch, collision and reset scenarios.
module tb_i2c_target_regs;

  localparam int Q = 12;

  logic clk = 1'b0;
  logic rst;
  logic [6:0] own_addr;
  logic scl_m, sda_m;
  int errors = 0;
  int checks = 0;
  int pulse_cnt = 0;
  logic watch_oe = 1'b0;
  logic oe_seen = 1'b0;
  logic [7:0] rx;
  logic ack;
  logic found;

  i2c_target_regs_if bus ();

  assign bus.scl_i = scl_m;
  assign bus.sda_i = sda_m & ~bus.sda_oe;

  i2c_target_regs #(.FILTER_LEN(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .own_addr (own_addr),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.wr_pulse) pulse_cnt++;
    if (watch_oe && bus.sda_oe) oe_seen = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b1; wait_clk(Q);
  endtask

  task automatic i2c_bit(input logic b, output logic seen);
    sda_m = b;    wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q / 2);
    seen = bus.sda_i;
    wait_clk(Q - Q / 2);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  // Eight data bits MSB first then the ninth (ACK) bit; rx/bit9 are what the bus carried.
  task automatic i2c_byte(input logic [7:0] tx, input logic ninth,
                          output logic [7:0] rxv, output logic bit9);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      i2c_bit(tx[i], s);
      rxv[i] = s;
    end
    i2c_bit(ninth, bit9);
  endtask

  initial begin
    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; own_addr = 7'h42;
    bus.host_we = 1'b0; bus.host_idx = 3'd0; bus.host_wdata = 8'h00;
    wait_clk(5);
    rst = 1'b0;
    wait_clk(2);

    chk("rst_sda_oe", 32'(bus.sda_oe), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_wr_pulse", 32'(bus.wr_pulse), 32'd0);
    chk("rst_wr_idx", 32'(bus.wr_idx), 32'd0);
    chk("rst_reg0", 32'(bus.host_rdata), 32'h00);
    chk("rst_state", 32'(dut.state_r), 32'd0);

    // Write 0xA5 to reg 3.
    i2c_start();
    i2c_byte(8'h84, 1'b1, rx, ack); chk("w_addr_ack", 32'(ack), 32'd0);
    chk("w_busy", 32'(bus.busy), 32'd1);
    i2c_byte(8'h03, 1'b1, rx, ack); chk("w_ptr_ack", 32'(ack), 32'd0);
    i2c_byte(8'hA5, 1'b1, rx, ack); chk("w_data_ack", 32'(ack), 32'd0);
    i2c_stop();
    chk("w_busy_after_stop", 32'(bus.busy), 32'd0);
    chk("w_pulse_count", 32'(pulse_cnt), 32'd1);
    chk("w_wr_idx", 32'(bus.wr_idx), 32'd3);
    bus.host_idx = 3'd3; wait_clk(1);
    chk("w_reg3", 32'(bus.host_rdata), 32'hA5);

    // Host preload, then pointer write + repeated START read with wrap.
    bus.host_we = 1'b1; bus.host_idx = 3'd7; bus.host_wdata = 8'h11; wait_clk(1);
    bus.host_idx = 3'd0; bus.host_wdata = 8'h22; wait_clk(1);
    bus.host_we = 1'b0; bus.host_idx = 3'd7; wait_clk(1);
    chk("host_reg7", 32'(bus.host_rdata), 32'h11);
    i2c_start();
    i2c_byte(8'h84, 1'b1, rx, ack); chk("r_addrw_ack", 32'(ack), 32'd0);
    i2c_byte(8'h07, 1'b1, rx, ack); chk("r_ptr_ack", 32'(ack), 32'd0);
    i2c_start();
    i2c_byte(8'h85, 1'b1, rx, ack); chk("r_addrr_ack", 32'(ack), 32'd0);
    i2c_byte(8'hFF, 1'b0, rx, ack); chk("r_byte0", 32'(rx), 32'h11);
    i2c_byte(8'hFF, 1'b1, rx, ack); chk("r_byte1", 32'(rx), 32'h22);
    wait_clk(Q);
    chk("r_oe_after_nack", 32'(bus.sda_oe), 32'd0);
    i2c_stop();
    chk("r_busy_after_stop", 32'(bus.busy), 32'd0);
    chk("r_no_pulse", 32'(pulse_cnt), 32'd1);

    // Wrong address: never pull SDA, ignore until STOP.
    oe_seen = 1'b0; watch_oe = 1'b1;
    i2c_start();
    i2c_byte(8'h86, 1'b1, rx, ack); chk("n_addr_nack", 32'(ack), 32'd1);
    chk("n_state_ignore", 32'(dut.state_r), 32'd9);
    chk("n_busy", 32'(bus.busy), 32'd0);
    i2c_byte(8'h84, 1'b1, rx, ack); chk("n_follow_nack", 32'(ack), 32'd1);
    i2c_stop();
    watch_oe = 1'b0;
    chk("n_oe_never", 32'(oe_seen), 32'd0);
    chk("n_state_idle", 32'(dut.state_r), 32'd0);

    // One-cycle SCL glitch must not count as a bit.
    i2c_start();
    chk("g_state_before", 32'(dut.state_r), 32'd1);
    scl_m = 1'b1; wait_clk(1);
    scl_m = 1'b0; wait_clk(Q);
    chk("g_bitcnt", 32'(dut.bit_cnt_r), 32'd0);
    chk("g_state_after", 32'(dut.state_r), 32'd1);
    i2c_byte(8'h84, 1'b1, rx, ack); chk("g_addr_ack", 32'(ack), 32'd0);
    i2c_stop();

    // Host and I2C write reg 2 in the same cycle: I2C value must remain.
    i2c_start();
    i2c_byte(8'h84, 1'b1, rx, ack); chk("c_addr_ack", 32'(ack), 32'd0);
    i2c_byte(8'h02, 1'b1, rx, ack); chk("c_ptr_ack", 32'(ack), 32'd0);
    found = 1'b0;
    fork
      i2c_byte(8'hC3, 1'b1, rx, ack);
      begin
        for (int k = 0; k < 2000; k++) begin
          @(negedge clk);
          if (dut.i2c_we_s) begin
            bus.host_idx = 3'd2; bus.host_wdata = 8'h5A; bus.host_we = 1'b1;
            found = 1'b1;
            @(negedge clk);
            bus.host_we = 1'b0;
            break;
          end
        end
      end
    join
    chk("c_write_seen", 32'(found), 32'd1);
    chk("c_data_ack", 32'(ack), 32'd0);
    i2c_stop();
    bus.host_idx = 3'd2; wait_clk(1);
    chk("c_reg2_i2c_wins", 32'(bus.host_rdata), 32'hC3);
    chk("c_wr_idx", 32'(bus.wr_idx), 32'd2);
    chk("c_pulse_count", 32'(pulse_cnt), 32'd2);

    // Reset in the middle of a read while SDA is being pulled low.
    i2c_start();
    i2c_byte(8'h84, 1'b1, rx, ack); chk("x_addrw_ack", 32'(ack), 32'd0);
    i2c_byte(8'h00, 1'b1, rx, ack); chk("x_ptr_ack", 32'(ack), 32'd0);
    i2c_start();
    i2c_byte(8'h85, 1'b1, rx, ack); chk("x_addrr_ack", 32'(ack), 32'd0);
    chk("x_oe_driving", 32'(bus.sda_oe), 32'd1);
    rst = 1'b1; wait_clk(1);
    chk("x_oe_released", 32'(bus.sda_oe), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.host_idx = 3'(i); wait_clk(1);
      chk($sformatf("x_reg%0d_zero", i), 32'(bus.host_rdata), 32'h00);
    end
    i2c_byte(8'h84, 1'b1, rx, ack); chk("x_no_ack0", 32'(ack), 32'd1);
    i2c_byte(8'h85, 1'b1, rx, ack); chk("x_no_ack1", 32'(ack), 32'd1);
    chk("x_state_idle", 32'(dut.state_r), 32'd0);
    chk("x_busy", 32'(bus.busy), 32'd0);
    i2c_stop();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
